// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO burst reader.
package fifo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_BURST
  } burst_rd_st_t;

  // Bits needed to hold values 0..max_val. Returns at least 1 so a zero max still sizes a legal vector.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/axis_skid2.sv
// Two-entry registered skid buffer: pushes land in the buffer, and the head entry drives a valid/ready stream.
module axis_skid2 #(
  parameter int G_W = 73
) (
  input  logic           i_clk,
  input  logic           i_arst_n,
  input  logic           i_sclr,
  input  logic           i_push,
  input  logic [G_W-1:0] i_pdat,
  output logic           o_full,
  output logic           o_valid,
  output logic [G_W-1:0] o_data,
  input  logic           i_ready
);

  logic [G_W-1:0] r_head;
  logic [G_W-1:0] r_tail;
  logic [1:0]     r_cnt;
  logic           w_pop;
  logic           w_push;

  assign w_pop   = (r_cnt != 2'd0) && i_ready;
  assign w_push  = i_push && ((r_cnt != 2'd2) || w_pop);
  assign o_full  = (r_cnt == 2'd2);
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_head;

  // NOTE: sequential state uses <= so every flop samples pre-edge values. The two data
  // entries are reset as well, because the stream data must read as zero out of reset.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else if (i_sclr) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= i_pdat;
          else               r_tail <= i_pdat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= i_pdat;
          end else begin
            r_head <= r_tail;
            r_tail <= i_pdat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO in bursts of G_BURST words onto a valid/ready stream, and flushes
// partial bursts after G_TMO idle cycles.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int G_W        = 72,
  parameter int G_D        = 512,
  parameter int ADDR_WIDTH = $clog2(G_D),
  parameter int G_BURST    = 16,
  parameter int G_TMO      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_sclr,
  input  logic                  i_fifo_empt,
  input  logic [G_W-1:0]        i_fifo_rdat,
  input  logic [ADDR_WIDTH:0]   i_fifo_flvl,
  output logic                  o_fifo_rena,
  output logic                  o_tvalid,
  output logic [G_W-1:0]        o_tdata,
  output logic                  o_tlast,
  input  logic                  i_tready,
  output logic                  o_busy,
  output logic                  o_flush_evt
);

  localparam int LEN_W  = cnt_w(G_BURST);
  localparam int TMO_W  = cnt_w(G_TMO);
  localparam int FLVL_W = ADDR_WIDTH + 1;

  localparam logic [LEN_W-1:0]  BURST_LEN = LEN_W'(G_BURST);
  localparam logic [FLVL_W-1:0] BURST_LVL = FLVL_W'(G_BURST);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(G_TMO);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'((G_TMO > 0) ? G_TMO - 1 : 0);

  burst_rd_st_t     r_state,    w_state_nxt;
  logic [TMO_W-1:0] r_tmo_cnt,  w_tmo_nxt;
  logic [LEN_W-1:0] r_beat_cnt, w_beat_nxt;
  logic [LEN_W-1:0] r_len,      w_len_nxt;
  logic             r_flush_evt;
  logic [LEN_W-1:0] w_flush_len;
  logic             w_flush_go;
  logic             w_pop;
  logic             w_last;
  logic             w_skid_full;
  logic             w_skid_valid;
  logic [G_W:0]     w_skid_dat;

  // A flush length is the pending level capped at a full burst, and never zero so the burst can close.
  always_comb begin
    w_flush_len = BURST_LEN;
    if (i_fifo_flvl < BURST_LVL) w_flush_len = LEN_W'(i_fifo_flvl);
    if (w_flush_len == '0)       w_flush_len = LEN_W'(1);
  end

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = r_tmo_cnt;
    w_beat_nxt  = r_beat_cnt;
    w_len_nxt   = r_len;
    w_flush_go  = 1'b0;
    w_pop       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_fifo_empt)               w_tmo_nxt = '0;
        else if (r_tmo_cnt != TMO_MAX) w_tmo_nxt = r_tmo_cnt + TMO_W'(1);
        if (i_fifo_flvl >= BURST_LVL) begin
          w_state_nxt = ST_BURST;
          w_len_nxt   = BURST_LEN;
          w_beat_nxt  = '0;
          w_tmo_nxt   = '0;
        end else if ((G_TMO != 0) && (r_tmo_cnt == TMO_LAST) && !i_fifo_empt) begin
          w_state_nxt = ST_BURST;
          w_len_nxt   = w_flush_len;
          w_beat_nxt  = '0;
          w_tmo_nxt   = '0;
          w_flush_go  = 1'b1;
        end
      end
      ST_BURST: begin
        w_tmo_nxt = '0;
        // Pop decision uses only registered skid occupancy, keeping i_tready off the FIFO read path.
        w_pop     = !i_fifo_empt && !w_skid_full;
        w_last    = (r_beat_cnt == r_len - LEN_W'(1));
        if (w_pop) begin
          w_beat_nxt = r_beat_cnt + LEN_W'(1);
          if (w_last) w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_len       <= '0;
      r_flush_evt <= 1'b0;
    end else if (i_sclr) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_len       <= '0;
      r_flush_evt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmo_cnt   <= w_tmo_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_len       <= w_len_nxt;
      r_flush_evt <= w_flush_go;
    end
  end

  axis_skid2 #(
    .G_W (G_W + 1)
  ) u_skid (
    .i_clk    (i_clk),
    .i_arst_n (i_arst_n),
    .i_sclr   (i_sclr),
    .i_push   (w_pop),
    .i_pdat   ({w_last, i_fifo_rdat}),
    .o_full   (w_skid_full),
    .o_valid  (w_skid_valid),
    .o_data   (w_skid_dat),
    .i_ready  (i_tready)
  );

  assign o_fifo_rena        = w_pop;
  assign o_tvalid           = w_skid_valid;
  assign {o_tlast, o_tdata} = w_skid_dat;
  assign o_busy             = (r_state != ST_IDLE) || w_skid_valid;
  assign o_flush_evt        = r_flush_evt;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based show-ahead FIFO feeds the reader, and a scoreboard
// checks stream order, burst boundaries, flush timing and clear/reset behaviour.
module tb_fifo_burst_reader;

  localparam int G_W     = 72;
  localparam int G_D     = 512;
  localparam int AW      = $clog2(G_D);
  localparam int G_BURST = 16;
  localparam int G_TMO   = 256;

  logic           i_clk       = 1'b0;
  logic           i_arst_n    = 1'b0;
  logic           i_sclr      = 1'b0;
  logic           i_fifo_empt = 1'b1;
  logic [G_W-1:0] i_fifo_rdat = '0;
  logic [AW:0]    i_fifo_flvl = '0;
  logic           i_tready    = 1'b0;
  logic           o_fifo_rena;
  logic           o_tvalid;
  logic [G_W-1:0] o_tdata;
  logic           o_tlast;
  logic           o_busy;
  logic           o_flush_evt;

  fifo_burst_reader #(
    .G_W     (G_W),
    .G_D     (G_D),
    .G_BURST (G_BURST),
    .G_TMO   (G_TMO)
  ) dut (
    .i_clk       (i_clk),
    .i_arst_n    (i_arst_n),
    .i_sclr      (i_sclr),
    .i_fifo_empt (i_fifo_empt),
    .i_fifo_rdat (i_fifo_rdat),
    .i_fifo_flvl (i_fifo_flvl),
    .o_fifo_rena (o_fifo_rena),
    .o_tvalid    (o_tvalid),
    .o_tdata     (o_tdata),
    .o_tlast     (o_tlast),
    .i_tready    (i_tready),
    .o_busy      (o_busy),
    .o_flush_evt (o_flush_evt)
  );

  bit clk_en = 1'b1;
  initial forever begin
    #5;
    if (clk_en) i_clk = ~i_clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  logic [G_W-1:0] fifo_q[$];
  logic [G_W-1:0] exp_q[$];
  int n_vec = 0, n_err = 0;
  int edge_cnt = 0, beats = 0, n_total = 0, wr_left = 0, wr_idx = 0;
  int flush_cnt = 0, pop_cnt = 0, in_flight = 0, last_xfer_edge = 0;
  int ne_edge = -1, flush_edge = -1;
  int rdy_mode = 0;  // 0: ready high, 1: toggle, 2: random, 3: held low
  bit seq_data = 1'b0, sclr_req = 1'b0, hold_prev = 1'b0;
  logic [G_W:0] hold_beat;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ctrl"}, {o_tvalid, o_tlast, o_fifo_rena, o_busy, o_flush_evt}, 5'b0);
    check({tag, "_tdata"}, o_tdata, '0);
  endtask

  function automatic logic [G_W-1:0] next_word();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return seq_data ? G_W'(wr_idx) : r[G_W-1:0];
  endfunction

  task automatic drive_fifo();
    i_fifo_empt = (fifo_q.size() == 0);
    i_fifo_rdat = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    i_fifo_flvl = (AW+1)'(fifo_q.size());
    if (fifo_q.size() != 0 && ne_edge < 0) ne_edge = edge_cnt;
  endtask

  // One clock: sample at the falling edge, then update the FIFO model and drive inputs just after the rising edge.
  task automatic cycle();
    bit pop, xfer, clr, exp_last;
    logic [G_W-1:0] w, exp_w;
    @(negedge i_clk);
    pop  = o_fifo_rena;
    xfer = o_tvalid && i_tready;
    clr  = i_sclr;
    if (hold_prev) check("hold_stable", {o_tvalid, o_tlast, o_tdata}, {1'b1, hold_beat});
    hold_prev = o_tvalid && !i_tready && !clr;
    hold_beat = {o_tlast, o_tdata};
    if (o_flush_evt) begin
      flush_cnt++;
      flush_edge = edge_cnt;
    end
    if (pop) begin
      check("pop_nonempty", fifo_q.size() != 0, 1'b1);
      pop_cnt++;
      in_flight++;
    end
    if (xfer && !clr) begin
      in_flight--;
      check("beat_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("tdata", o_tdata, exp_w);
        exp_last = (((beats + 1) % G_BURST) == 0) || (beats + 1 == n_total);
        check("tlast", o_tlast, exp_last);
        if (rdy_mode == 0 && (beats % G_BURST) != 0)
          check("throughput", edge_cnt - last_xfer_edge, 1);
        last_xfer_edge = edge_cnt;
        beats++;
      end
    end
    if (pop) check("skid_bound", in_flight <= 2, 1'b1);
    @(posedge i_clk);
    edge_cnt++;
    #1;
    if (clr) begin
      fifo_q.delete();
      exp_q.delete();
      in_flight = 0;
      wr_left   = 0;
    end else begin
      if (pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (wr_left > 0) begin
        w = next_word();
        fifo_q.push_back(w);
        exp_q.push_back(w);
        wr_left--;
        wr_idx++;
      end
    end
    drive_fifo();
    i_sclr   = sclr_req;
    sclr_req = 1'b0;
    case (rdy_mode)
      0:       i_tready = 1'b1;
      1:       i_tready = !i_tready;
      2:       i_tready = 1'($urandom_range(0, 1));
      default: i_tready = 1'b0;
    endcase
  endtask

  task automatic start_fill(input int n, input int mode, input bit seq);
    n_total    = n;
    beats      = 0;
    flush_cnt  = 0;
    pop_cnt    = 0;
    wr_left    = n;
    wr_idx     = 0;
    rdy_mode   = mode;
    seq_data   = seq;
    ne_edge    = -1;
    flush_edge = -1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((beats < n_total || o_busy) && guard < 3000) begin
      cycle();
      guard++;
    end
    check({tag, "_beats"}, beats, n_total);
    check({tag, "_flush_cnt"}, flush_cnt, (n_total % G_BURST) != 0);
    check({tag, "_fifo_left"}, fifo_q.size(), 0);
  endtask

  initial begin
    logic [G_W-1:0] head;
    int guard;
    drive_fifo();
    #1;
    check_idle("reset");
    repeat (2) @(posedge i_clk);
    #1;
    i_arst_n = 1'b1;
    repeat (3) cycle();
    #2;
    check_idle("post_reset");

    // 16 sequential words, ready high: one full burst.
    start_fill(16, 0, 1'b1);
    drain("t1");

    // 5 words: a flushed partial burst after the timeout.
    start_fill(5, 0, 1'b0);
    drain("t2");
    check("t2_flush_delay", flush_edge - ne_edge, G_TMO);

    // 40 words with toggling ready: 16, 16, then an 8-word flush.
    start_fill(40, 1, 1'b0);
    drain("t3");

    // Ready held low at burst start: the skid fills with two words and popping stops.
    start_fill(16, 3, 1'b0);
    guard = 0;
    while (pop_cnt == 0 && guard < 200) begin
      cycle();
      guard++;
    end
    repeat (10) cycle();
    check("t4_pops", pop_cnt, 2);
    head = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("t4_head", {o_tvalid, o_tdata}, {1'b1, head});
    rdy_mode = 2;
    drain("t4");

    // Synchronous clear mid-burst, then a fresh fill.
    start_fill(16, 0, 1'b0);
    guard = 0;
    while (beats < 7 && guard < 200) begin
      cycle();
      guard++;
    end
    sclr_req = 1'b1;
    cycle();
    cycle();
    #2;
    check_idle("t5_sclr");
    start_fill(16, 0, 1'b0);
    drain("t5_refill");

    // Asynchronous reset mid-burst with the clock stopped.
    start_fill(16, 0, 1'b0);
    guard = 0;
    while (beats < 5 && guard < 200) begin
      cycle();
      guard++;
    end
    @(negedge i_clk);
    clk_en = 1'b0;
    #2;
    i_arst_n = 1'b0;
    #1;
    check_idle("t6_async");
    fifo_q.delete();
    exp_q.delete();
    wr_left   = 0;
    in_flight = 0;
    hold_prev = 1'b0;
    drive_fifo();
    #5;
    i_arst_n = 1'b1;
    #2;
    clk_en = 1'b1;
    start_fill(16, 0, 1'b0);
    drain("t6_after");

    // Random fill sizes with random ready.
    for (int k = 0; k < 4; k++) begin
      start_fill(int'($urandom_range(1, 40)), 2, 1'b0);
      drain("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
